// File: rtl/key_beep_tone.sv
// Key-selected square-wave tone generator: each press starts, switches or stops a tone.
// Optional macro BEEP_AUTO_OFF_EN ends a tone after TIMEOUT_CYC clocks of play.
module key_beep_tone #(
  parameter int KEY_NUM     = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 18,
  parameter int BASE_HALF   = 191112,
  parameter int STEP        = 20000,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_filter,
  output logic               beep,
  output logic               beep_en,
  output logic [IDX_W-1:0]   tone_idx
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_e             state_q, state_d;
  logic               beep_q, beep_d;
  logic               beep_en_q, beep_en_d;
  logic [IDX_W-1:0]   tone_q, tone_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_NUM-1:0] key_d1_q, key_d1_d, key_d2_q, key_d2_d;
  logic               init_q;

  logic [KEY_NUM-1:0] press;
  logic               any_press;
  logic [IDX_W-1:0]   sel;
  logic [CNT_W-1:0]   half_m1;
  logic               timeout;
  logic               restart;

  // The first edge after reset loads both stages from the pins, so a key
  // already held low across reset release never looks like a fresh press.
  always_comb begin
    key_d1_d = key_filter;
    key_d2_d = init_q ? key_d1_q : key_filter;
  end

  always_comb begin
    press     = key_d2_q & ~key_d1_q;
    any_press = |press;
    sel       = '0;
    for (int k = KEY_NUM - 1; k >= 0; k--) begin
      if (press[k]) sel = IDX_W'(k);
    end
  end

  assign half_m1 = BASE_C - CNT_W'(tone_q) * STEP_C - CNT_W'(1);

`ifdef BEEP_AUTO_OFF_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_q, to_d;

  assign timeout = (state_q == PLAY) && (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d = to_q + TO_W'(1);
    if (state_q == IDLE || restart) to_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) to_q <= '0;
    else            to_q <= to_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // Press beats timeout, which beats the half-period wrap.
  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    tone_d  = tone_q;
    cnt_d   = cnt_q;
    restart = 1'b0;
    if (state_q == IDLE) begin
      cnt_d  = '0;
      beep_d = 1'b0;
      if (any_press) begin
        state_d = PLAY;
        tone_d  = sel;
        beep_d  = 1'b1;
      end
    end else if (any_press) begin
      cnt_d = '0;
      if (sel == tone_q) begin
        state_d = IDLE;
        beep_d  = 1'b0;
      end else begin
        tone_d  = sel;
        beep_d  = 1'b1;
        restart = 1'b1;
      end
    end else if (timeout) begin
      state_d = IDLE;
      beep_d  = 1'b0;
      cnt_d   = '0;
    end else if (cnt_q == half_m1) begin
      cnt_d  = '0;
      beep_d = ~beep_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    beep_en_d = (state_d == PLAY);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      beep_q    <= 1'b0;
      beep_en_q <= 1'b0;
      tone_q    <= '0;
      cnt_q     <= '0;
      key_d1_q  <= '1;
      key_d2_q  <= '1;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beep_q    <= beep_d;
      beep_en_q <= beep_en_d;
      tone_q    <= tone_d;
      cnt_q     <= cnt_d;
      key_d1_q  <= key_d1_d;
      key_d2_q  <= key_d2_d;
      init_q    <= 1'b1;
    end
  end

  assign beep     = beep_q;
  assign beep_en  = beep_en_q;
  assign tone_idx = tone_q;

endmodule
